riscv_lsu: RTL
==============

Name: riscv_lsu

Overview:
Load-store unit that is the responder to the core's data-memory request interface (req/we/size/addr/wd in; read data and stall out). It turns a core access into a byte-enabled, word-aligned request on a variable-latency data-memory port, and holds the core stalled until the transaction completes. It aligns and replicates store data, and extracts and sign- or zero-extends load data. It sits between riscv_core and the data memory inside the processor unit.

Parameters:
MEM_TIMEOUT, 255, number of REQ-state cycles without mem_ready_i before the access is aborted with an error; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
core_req_i  in  1  core requests a data access this cycle
core_we_i  in  1  1 = store, 0 = load
core_size_i  in  3  funct3 encoding: 0=B, 1=H, 2=W, 4=BU, 5=HU
core_addr_i  in  32  byte address
core_wd_i  in  32  store data, LSB-aligned
core_rd_o  out  32  load result, extended; valid in the DONE cycle
core_stall_o  out  1  core must hold its state and request
core_err_o  out  1  one-cycle pulse: misaligned or illegal access, or timeout
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write
mem_be_o  out  4  byte enables
mem_addr_o  out  32  word address, bits [1:0] = 00
mem_wd_o  out  32  lane-replicated store data
mem_rd_i  in  32  memory read word, valid with mem_ready_i
mem_ready_i  in  1  memory completes the request this cycle

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset effects: state = IDLE, timeout counter = 0, all registered outputs = 0. The mem_* outputs are 0 outside REQ.
- FSM states are IDLE, REQ and DONE.
- IDLE:
  - core_req_i with a legal, aligned access: latch we/size/addr/wd, go to REQ. core_stall_o = 1 combinationally in this same cycle.
  - core_req_i with an illegal size (3, 6, 7), a half access at addr[0] = 1, or a word access at addr[1:0] != 0: no memory access, core_err_o = 1 for this one cycle, core_stall_o = 0, core_rd_o = 0, stay in IDLE.
- REQ:
  - mem_req_o = 1, and all mem_* outputs are held stable from the latched values until mem_ready_i.
  - On mem_ready_i: register the extended load data (0 for stores) and go to DONE. This may occur in the first REQ cycle, giving a minimum total latency of 2 cycles.
  - The timeout counter increments in each REQ cycle without ready. When it reaches MEM_TIMEOUT (and MEM_TIMEOUT != 0): go to DONE, core_rd_o = 0, and core_err_o pulses in the DONE cycle.
  - core_stall_o = 1.
- DONE:
  - core_stall_o = 0 and core_rd_o is valid; the core retires the access this cycle.
  - Unconditionally go to IDLE; the counter clears.
  - A new core_req_i is seen in the next cycle (back-to-back accesses cost 3 cycles each at zero memory wait).
- Stall rule: core_stall_o = core_req_i && (state != DONE) && legal access.
- Byte enables (off = addr[1:0]):
  - B/BU: 4'b0001 << off.
  - H/HU: addr[1] ? 4'b1100 : 4'b0011.
  - W: 4'b1111.
  - mem_be_o is driven for loads too.
- Store data:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- Load data:
  - Select byte mem_rd_i[8*off +: 8] or half mem_rd_i[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- core_rd_o holds its value from DONE until the next DONE or reset.
- mem_ready_i outside REQ is ignored.
- Reset in any state: the next state is IDLE, the in-flight access is abandoned, and mem_req_o = 0 after the edge.

Test Plan:
- Load LB from addr 0x103; memory returns 0x80FF_1234 with ready in the 2nd REQ cycle → mem_be_o = 0001<<3 = 1000, mem_addr_o = 0x100, stall high for 3 cycles, DONE core_rd_o = 0xFFFF_FF80. Same access with LBU → 0x0000_0080.
- Store SH of wd = 0xDEAD_BEEF to addr 0x22 with immediate ready → mem_we_o = 1, be = 1100, mem_wd_o = 0xBEEF_BEEF, mem_addr_o = 0x20, DONE the next cycle, core_rd_o = 0.
- LW at addr 0x6 and size = 3 at addr 0x0 → core_err_o pulses 1 cycle, mem_req_o stays 0, stall 0.
- MEM_TIMEOUT = 4 with ready never asserted → mem_req_o high for 4 cycles, then DONE with core_err_o = 1 and core_rd_o = 0, then IDLE.
- rst_i asserted in the 2nd REQ cycle → after the edge: IDLE, mem_req_o = 0, stall = 0. A later ready pulse causes no DONE.
- Back-to-back LW 0x0 then LHU 0x2 with a continuous core_req_i and ready every REQ cycle → two separate DONE cycles 3 cycles apart, with correct data for each.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu - load/store unit between the core data port and a
// variable-latency, word-organised data memory.
//
// A core access is checked for legality and alignment, latched, and
// presented to memory as a word-aligned, byte-enabled request. The core
// is stalled until the memory answers, or until the timeout expires.
// Store data is replicated across the byte lanes. Load data is extracted
// from the returned word and then sign- or zero-extended.
//
// Ports
//   clk_i, rst_i      clock; synchronous active-high reset
//   core_req_i        core requests a data access
//   core_we_i         1 = store, 0 = load
//   core_size_i[2:0]  funct3 size: 0=B 1=H 2=W 4=BU 5=HU
//   core_addr_i[31:0] byte address
//   core_wd_i[31:0]   store data, LSB-aligned
//   core_rd_o[31:0]   extended load result, valid in DONE, held until next DONE
//   core_stall_o      core must hold state and request
//   core_err_o        one-cycle pulse: illegal/misaligned access or timeout
//   mem_req_o         memory request (REQ state only)
//   mem_we_o          memory write
//   mem_be_o[3:0]     byte enables
//   mem_addr_o[31:0]  word address, [1:0] = 00
//   mem_wd_o[31:0]    lane-replicated store data
//   mem_rd_i[31:0]    memory read word, valid with mem_ready_i
//   mem_ready_i       memory completes the request this cycle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a core request; illegal requests answered here
// REQ   | memory request outstanding, counting cycles toward timeout
// DONE  | result presented to the core for one cycle, stall released
module riscv_lsu #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // The access ends in the REQ cycle where the count of earlier
    // ready-less cycles equals MEM_TIMEOUT-1, so exactly MEM_TIMEOUT
    // REQ cycles are spent before giving up.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((MEM_TIMEOUT == 0) ? 0 : (MEM_TIMEOUT - 1));
    localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [2:0]       size_q, size_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wd_q, wd_d;
    logic [31:0]      rd_q, rd_d;
    logic             to_err_q, to_err_d;

    logic             access_legal;
    logic             illegal_req;
    logic             in_req;

    function automatic logic is_legal(input logic [2:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            3'd0, 3'd4: ok = 1'b1;
            3'd1, 3'd5: ok = ~off[0];
            3'd2:       ok = (off == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Only legal sizes are ever latched, so size[1:0] fully selects the width.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size[1:0])
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size[1:0])
            2'd0:    d = {4{wd[7:0]}};
            2'd1:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_data(input logic [2:0]  size,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        b = word[8*off +: 8];
        h = word[16*off[1] +: 16];
        case (size)
            3'd0:    d = {{24{b[7]}}, b};
            3'd4:    d = {24'd0, b};
            3'd1:    d = {{16{h[15]}}, h};
            3'd5:    d = {16'd0, h};
            default: d = word;
        endcase
        return d;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wd_q     <= '0;
            rd_q     <= '0;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            rd_q     <= rd_d;
            to_err_q <= to_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        rd_d     = rd_q;
        to_err_d = to_err_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                to_err_d = 1'b0;
                if (core_req_i && access_legal) begin
                    we_d    = core_we_i;
                    size_d  = core_size_i;
                    addr_d  = core_addr_i;
                    wd_d    = core_wd_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ready_i) begin
                    rd_d    = we_q ? 32'd0 : load_data(size_q, addr_q[1:0], mem_rd_i);
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    rd_d     = 32'd0;
                    to_err_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                cnt_d    = '0;
                to_err_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        access_legal = is_legal(core_size_i, core_addr_i[1:0]);
        illegal_req  = (state_q == ST_IDLE) && core_req_i && !access_legal;
        in_req       = (state_q == ST_REQ);

        core_stall_o = core_req_i && (state_q != ST_DONE) && access_legal;
        core_err_o   = illegal_req || ((state_q == ST_DONE) && to_err_q);
        core_rd_o    = illegal_req ? 32'd0 : rd_q;

        mem_req_o    = in_req;
        mem_we_o     = in_req && we_q;
        mem_be_o     = in_req ? byte_en(size_q, addr_q[1:0]) : 4'b0000;
        mem_addr_o   = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_wd_o     = in_req ? store_data(size_q, wd_q) : 32'd0;
    end

endmodule
